// File: rtl/nes_intc_pkg.sv
// Shared definitions for the interrupt entry path: sequencer states, stack-pointer mux
// codes and vector-mux/exception codes.
package nes_intc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SWAP     = 3'd1,
        ST_DEC1     = 3'd2,
        ST_PUSH_PSR = 3'd3,
        ST_DEC2     = 3'd4,
        ST_PUSH_PC  = 3'd5,
        ST_LDVEC    = 3'd6,
        ST_DONE     = 3'd7
    } seq_state_t;

    localparam logic [1:0] SP_SAVED_USP = 2'b00;
    localparam logic [1:0] SP_PLUS_ONE  = 2'b01;
    localparam logic [1:0] SP_MINUS_ONE = 2'b10;
    localparam logic [1:0] SP_SAVED_SSP = 2'b11;

    localparam logic [1:0] EXC_ACV     = 2'b00;
    localparam logic [1:0] EXC_ILLEGAL = 2'b01;
    localparam logic [1:0] EXC_PRIV    = 2'b10;
    localparam logic [1:0] VEC_IRQ     = 2'b11;

    // Source index width; a single source still needs a 1-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/int_seq_if.sv
// Request/strobe bundle between the CPU control FSM, the push path, intc and int_seq.
interface int_seq_if #(parameter int NUM_SRC = 4);

    logic [NUM_SRC-1:0]   irq_req;
    logic [3*NUM_SRC-1:0] irq_pri;
    logic [8*NUM_SRC-1:0] irq_vec;
    logic                 exc_req;
    logic [1:0]           exc_type;
    logic                 boundary;
    logic                 cur_priv;
    logic [2:0]           cur_priority;
    logic                 push_ack;

    logic                 busy;
    logic                 done;
    logic [NUM_SRC-1:0]   irq_ack;
    logic                 push_req;
    logic                 push_sel;
    logic [2:0]           int_priority;
    logic [7:0]           int_vec;
    logic                 table_mux_sel;
    logic                 ld_vector;
    logic [1:0]           vector_mux;
    logic                 ld_priv;
    logic                 set_priv;
    logic                 ld_priority;
    logic                 psr_mux_sel;
    logic                 gate_psr;
    logic                 ld_saved_usp;
    logic                 ld_saved_ssp;
    logic                 gate_sp_en;
    logic [1:0]           sp_mux_sel;
    logic                 sr1_sel_r6;
    logic                 ld_r6;

    modport master (
        output irq_req, irq_pri, irq_vec, exc_req, exc_type, boundary,
               cur_priv, cur_priority, push_ack,
        input  busy, done, irq_ack, push_req, push_sel, int_priority, int_vec,
               table_mux_sel, ld_vector, vector_mux, ld_priv, set_priv, ld_priority,
               psr_mux_sel, gate_psr, ld_saved_usp, ld_saved_ssp, gate_sp_en,
               sp_mux_sel, sr1_sel_r6, ld_r6
    );

    modport slave (
        input  irq_req, irq_pri, irq_vec, exc_req, exc_type, boundary,
               cur_priv, cur_priority, push_ack,
        output busy, done, irq_ack, push_req, push_sel, int_priority, int_vec,
               table_mux_sel, ld_vector, vector_mux, ld_priv, set_priv, ld_priority,
               psr_mux_sel, gate_psr, ld_saved_usp, ld_saved_ssp, gate_sp_en,
               sp_mux_sel, sr1_sel_r6, ld_r6
    );

endinterface

// File: rtl/int_arb.sv
// Combinational priority arbiter: highest priority wins, ties to the lowest index,
// eligible only when strictly above the current processor priority.
module int_arb
    import nes_intc_pkg::*;
#(
    parameter int NUM_SRC = 4,
    localparam int IW = idx_w(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]   i_req,
    input  logic [3*NUM_SRC-1:0] i_pri,
    input  logic [8*NUM_SRC-1:0] i_vec,
    input  logic [2:0]           i_cur_priority,
    output logic [IW-1:0]        o_idx,
    output logic [2:0]           o_pri,
    output logic [7:0]           o_vec,
    output logic                 o_eligible
);

    logic [IW-1:0] w_idx;
    logic [2:0]    w_pri;
    logic [7:0]    w_vec;

    // Strict '>' keeps the earliest index on ties and never selects priority 0.
    always_comb begin
        w_idx = '0;
        w_pri = '0;
        w_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_req[i] && (i_pri[3*i +: 3] > w_pri)) begin
                w_idx = i[IW-1:0];
                w_pri = i_pri[3*i +: 3];
                w_vec = i_vec[8*i +: 8];
            end
        end
    end

    assign o_idx      = w_idx;
    assign o_pri      = w_pri;
    assign o_vec      = w_vec;
    assign o_eligible = (w_pri > i_cur_priority);

endmodule

// File: rtl/int_seq.sv
// Trap entry sequencer: accepts an exception or interrupt at an instruction boundary and
// walks intc through stack swap, PSR/PC push and vector load.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a boundary with an exception or eligible irq
// SWAP     | user trap: save R6 to saved_usp, load R6 from saved_ssp
// DEC1     | R6 <= R6 - 1 ahead of the PSR push
// PUSH_PSR | push old PSR, hold until push_ack
// DEC2     | R6 <= R6 - 1 ahead of the PC push
// PUSH_PC  | push PC, hold until push_ack
// LDVEC    | load vector/privilege/priority, ack the serviced source
// DONE     | table_vector valid, CPU fetches handler address
module int_seq
    import nes_intc_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic      clk,
    input  logic      rst,
    int_seq_if.slave  bus
);

    localparam int IW = idx_w(NUM_SRC);

    seq_state_t r_state, w_next;

    logic          r_is_irq;
    logic [1:0]    r_exc_type;
    logic [IW-1:0] r_idx;
    logic [2:0]    r_pri;
    logic [7:0]    r_vec;

    logic [IW-1:0] w_win_idx;
    logic [2:0]    w_win_pri;
    logic [7:0]    w_win_vec;
    logic          w_eligible;
    logic          w_accept;

    int_arb #(.NUM_SRC(NUM_SRC)) u_arb (
        .i_req          (bus.irq_req),
        .i_pri          (bus.irq_pri),
        .i_vec          (bus.irq_vec),
        .i_cur_priority (bus.cur_priority),
        .o_idx          (w_win_idx),
        .o_pri          (w_win_pri),
        .o_vec          (w_win_vec),
        .o_eligible     (w_eligible)
    );

    assign w_accept = (r_state == ST_IDLE) && bus.boundary && (bus.exc_req || w_eligible);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_is_irq   <= 1'b0;
            r_exc_type <= '0;
            r_idx      <= '0;
            r_pri      <= '0;
            r_vec      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_is_irq   <= !bus.exc_req;
                r_exc_type <= bus.exc_type;
                r_idx      <= w_win_idx;
                r_pri      <= w_win_pri;
                r_vec      <= w_win_vec;
            end
        end
    end

    // The privilege sampled at accept is captured by the choice of SWAP versus DEC1.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (w_accept) w_next = bus.cur_priv ? ST_SWAP : ST_DEC1;
            ST_SWAP:     w_next = ST_DEC1;
            ST_DEC1:     w_next = ST_PUSH_PSR;
            ST_PUSH_PSR: if (bus.push_ack) w_next = ST_DEC2;
            ST_DEC2:     w_next = ST_PUSH_PC;
            ST_PUSH_PC:  if (bus.push_ack) w_next = ST_LDVEC;
            ST_LDVEC:    w_next = ST_DONE;
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    logic               w_done, w_push_req, w_push_sel, w_table_mux_sel, w_ld_vector;
    logic               w_ld_priv, w_ld_priority, w_gate_psr, w_ld_saved_usp;
    logic               w_gate_sp_en, w_sr1_sel_r6, w_ld_r6;
    logic [1:0]         w_vector_mux, w_sp_mux_sel;
    logic [NUM_SRC-1:0] w_irq_ack;

    always_comb begin
        w_done          = 1'b0;
        w_push_req      = 1'b0;
        w_push_sel      = 1'b0;
        w_table_mux_sel = 1'b0;
        w_ld_vector     = 1'b0;
        w_ld_priv       = 1'b0;
        w_ld_priority   = 1'b0;
        w_gate_psr      = 1'b0;
        w_ld_saved_usp  = 1'b0;
        w_gate_sp_en    = 1'b0;
        w_sr1_sel_r6    = 1'b0;
        w_ld_r6         = 1'b0;
        w_vector_mux    = 2'b00;
        w_sp_mux_sel    = SP_SAVED_USP;
        w_irq_ack       = '0;
        case (r_state)
            ST_SWAP: begin
                w_sr1_sel_r6   = 1'b1;
                w_ld_saved_usp = 1'b1;
                w_gate_sp_en   = 1'b1;
                w_sp_mux_sel   = SP_SAVED_SSP;
                w_ld_r6        = 1'b1;
            end
            ST_DEC1, ST_DEC2: begin
                w_sr1_sel_r6 = 1'b1;
                w_gate_sp_en = 1'b1;
                w_sp_mux_sel = SP_MINUS_ONE;
                w_ld_r6      = 1'b1;
            end
            ST_PUSH_PSR: begin
                w_push_req = 1'b1;
                w_gate_psr = 1'b1;
            end
            ST_PUSH_PC: begin
                w_push_req = 1'b1;
                w_push_sel = 1'b1;
            end
            ST_LDVEC: begin
                w_ld_vector     = 1'b1;
                w_table_mux_sel = 1'b1;
                w_ld_priv       = 1'b1;
                if (r_is_irq) begin
                    w_vector_mux  = VEC_IRQ;
                    w_ld_priority = 1'b1;
                    for (int i = 0; i < NUM_SRC; i++)
                        w_irq_ack[i] = (r_idx == i[IW-1:0]);
                end else begin
                    w_vector_mux = r_exc_type;
                end
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.done          = w_done;
    assign bus.irq_ack       = w_irq_ack;
    assign bus.push_req      = w_push_req;
    assign bus.push_sel      = w_push_sel;
    assign bus.int_priority  = r_pri;
    assign bus.int_vec       = r_vec;
    assign bus.table_mux_sel = w_table_mux_sel;
    assign bus.ld_vector     = w_ld_vector;
    assign bus.vector_mux    = w_vector_mux;
    assign bus.ld_priv       = w_ld_priv;
    assign bus.set_priv      = 1'b0;
    assign bus.ld_priority   = w_ld_priority;
    assign bus.psr_mux_sel   = 1'b0;
    assign bus.gate_psr      = w_gate_psr;
    assign bus.ld_saved_usp  = w_ld_saved_usp;
    assign bus.ld_saved_ssp  = 1'b0;
    assign bus.gate_sp_en    = w_gate_sp_en;
    assign bus.sp_mux_sel    = w_sp_mux_sel;
    assign bus.sr1_sel_r6    = w_sr1_sel_r6;
    assign bus.ld_r6         = w_ld_r6;

endmodule

// File: tb/tb_int_seq.sv
// Directed bench for int_seq: table of trap scenarios plus hand-written reset sequences.
module tb_int_seq;

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    int_seq_if #(.NUM_SRC(4)) bus ();

    int_seq #(.NUM_SRC(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        priv;
        logic [2:0]  cprio;
        logic [3:0]  req;
        logic [11:0] pri;
        logic [31:0] vec;
        logic        exc;
        logic [1:0]  etype;
        int          n_wait;
        logic        accept;
        int          lat;
        logic        swap;
        logic [1:0]  vm;
        logic        ldp;
        logic [3:0]  ack;
        logic [7:0]  ivec;
        logic [2:0]  ipri;
        logic        chk_vec;
    } vec_t;

    vec_t tv[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [34:0] all_outs();
        return {bus.busy, bus.done, bus.irq_ack, bus.push_req, bus.push_sel,
                bus.int_priority, bus.int_vec, bus.table_mux_sel, bus.ld_vector,
                bus.vector_mux, bus.ld_priv, bus.set_priv, bus.ld_priority,
                bus.psr_mux_sel, bus.gate_psr, bus.ld_saved_usp, bus.ld_saved_ssp,
                bus.gate_sp_en, bus.sp_mux_sel, bus.sr1_sel_r6, bus.ld_r6};
    endfunction

    task automatic apply_inputs(input vec_t v);
        bus.cur_priv     = v.priv;
        bus.cur_priority = v.cprio;
        bus.irq_req      = v.req;
        bus.irq_pri      = v.pri;
        bus.irq_vec      = v.vec;
        bus.exc_req      = v.exc;
        bus.exc_type     = v.etype;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int         cyc, held, acks;
        logic       seen_done, saw_swap, swap_ok, any_busy;
        logic [1:0] vm;
        logic       ldp;
        logic [3:0] ack;
        logic [7:0] iv;
        logic [2:0] ip;
        string      tag;
        tag = $sformatf("v%0d", id);
        cyc = 1; held = 0; acks = 0;
        seen_done = 0; saw_swap = 0; swap_ok = 0; any_busy = 0;
        vm = 2'bxx; ldp = 1'bx; ack = 4'bxxxx; iv = 8'hxx; ip = 3'bxxx;

        @(negedge clk);
        apply_inputs(v);
        bus.boundary = 1'b1;
        bus.push_ack = 1'b1;
        @(negedge clk);
        bus.boundary = 1'b0;

        if (!v.accept) begin
            for (int i = 0; i < 8; i++) begin
                if (bus.busy) any_busy = 1'b1;
                @(negedge clk);
            end
            check({tag, "_no_accept_busy"}, any_busy, 0);
            return;
        end

        while (!seen_done && cyc <= 40) begin
            if (bus.ld_saved_usp) begin
                saw_swap = 1'b1;
                swap_ok  = (bus.sp_mux_sel == 2'b11) && bus.ld_r6 && bus.sr1_sel_r6 && bus.gate_sp_en;
            end
            if (bus.ld_vector) begin
                vm  = bus.vector_mux;
                ldp = bus.ld_priority;
                ack = bus.irq_ack;
                iv  = bus.int_vec;
                ip  = bus.int_priority;
            end
            if (bus.irq_ack != 4'b0000) acks++;
            if (bus.done) begin
                seen_done = 1'b1;
            end else begin
                if (bus.push_req && !bus.push_sel && held < v.n_wait) begin
                    check({tag, "_bp_hold"}, {bus.push_req, bus.gate_psr, bus.push_sel}, 3'b110);
                    held++;
                    bus.push_ack = 1'b0;
                end else begin
                    bus.push_ack = 1'b1;
                end
                // Inputs change after accept; the sequence must keep its latched view.
                if (cyc == 2) begin
                    bus.irq_pri      = 12'hFFF;
                    bus.irq_vec      = 32'hFFFF_FFFF;
                    bus.irq_req      = 4'b1111;
                    bus.exc_type     = 2'b11;
                    bus.cur_priority = 3'd0;
                end
                bus.boundary = (cyc == 3);
                @(negedge clk);
                cyc++;
            end
        end
        bus.boundary = 1'b0;
        bus.push_ack = 1'b1;

        check({tag, "_latency"}, cyc, v.lat);
        check({tag, "_swap_seen"}, saw_swap, v.swap);
        if (v.swap) check({tag, "_swap_strobes"}, swap_ok, 1);
        check({tag, "_vector_mux"}, vm, v.vm);
        check({tag, "_ld_priority"}, ldp, v.ldp);
        check({tag, "_irq_ack"}, ack, v.ack);
        check({tag, "_ack_cycles"}, acks, v.exc ? 0 : 1);
        if (v.chk_vec) check({tag, "_int_vec_pri"}, {iv, ip}, {v.ivec, v.ipri});
        @(negedge clk);
        check({tag, "_post_idle"}, {bus.done, bus.busy}, 2'b00);
    endtask

    initial begin
        logic found, stray;

        //          priv cpr req      pri      vec            exc typ  wt  acc lat sw  vm     ldp ack      ivec   ipri  chk
        tv[0] = '{1'b0, 3'd2, 4'b0010, 12'h028, 32'h0000_8000, 1'b0, 2'b00, 0, 1'b1, 6, 1'b0, 2'b11, 1'b1, 4'b0010, 8'h80, 3'd5, 1'b1};
        tv[1] = '{1'b1, 3'd2, 4'b0010, 12'h028, 32'h0000_8000, 1'b0, 2'b00, 0, 1'b1, 7, 1'b1, 2'b11, 1'b1, 4'b0010, 8'h80, 3'd5, 1'b1};
        tv[2] = '{1'b0, 3'd3, 4'b0101, 12'h104, 32'h0040_0020, 1'b0, 2'b00, 0, 1'b1, 6, 1'b0, 2'b11, 1'b1, 4'b0001, 8'h20, 3'd4, 1'b1};
        tv[3] = '{1'b0, 3'd4, 4'b0101, 12'h104, 32'h0040_0020, 1'b0, 2'b00, 0, 1'b0, 0, 1'b0, 2'b00, 1'b0, 4'b0000, 8'h00, 3'd0, 1'b0};
        tv[4] = '{1'b0, 3'd2, 4'b0010, 12'h028, 32'h0000_8000, 1'b1, 2'b10, 0, 1'b1, 6, 1'b0, 2'b10, 1'b0, 4'b0000, 8'h00, 3'd0, 1'b0};
        tv[5] = '{1'b0, 3'd2, 4'b0010, 12'h028, 32'h0000_8000, 1'b0, 2'b00, 3, 1'b1, 9, 1'b0, 2'b11, 1'b1, 4'b0010, 8'h80, 3'd5, 1'b1};
        tv[6] = '{1'b1, 3'd0, 4'b1111, 12'hD91, 32'h3322_1100, 1'b0, 2'b00, 0, 1'b1, 7, 1'b1, 2'b11, 1'b1, 4'b0100, 8'h22, 3'd6, 1'b1};
        tv[7] = '{1'b1, 3'd0, 4'b0000, 12'h000, 32'h0000_0000, 1'b1, 2'b00, 0, 1'b1, 7, 1'b1, 2'b00, 1'b0, 4'b0000, 8'h00, 3'd0, 1'b0};
        tv[8] = '{1'b0, 3'd0, 4'b0001, 12'h000, 32'h0000_0055, 1'b0, 2'b00, 0, 1'b0, 0, 1'b0, 2'b00, 1'b0, 4'b0000, 8'h00, 3'd0, 1'b0};
        tv[9] = '{1'b0, 3'd5, 4'b0000, 12'h000, 32'h0000_0000, 1'b1, 2'b01, 1, 1'b1, 7, 1'b0, 2'b01, 1'b0, 4'b0000, 8'h00, 3'd0, 1'b0};

        rst = 1'b1;
        apply_inputs(tv[8]);
        bus.irq_req  = 4'b0000;
        bus.boundary = 1'b0;
        bus.push_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_outs", all_outs(), 0);

        for (int i = 0; i < 10; i++) run_vec(tv[i], i);

        // Reset asserted while waiting in PUSH_PC: back to IDLE with no ack or done.
        @(negedge clk);
        apply_inputs(tv[0]);
        bus.boundary = 1'b1;
        bus.push_ack = 1'b1;
        @(negedge clk);
        bus.boundary = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.push_req && bus.push_sel) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_push_pc", found, 1);
        bus.push_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_outs", all_outs(), 0);
        rst = 1'b0;
        bus.push_ack = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done || (bus.irq_ack != 4'b0000) || bus.busy) stray = 1'b1;
            @(negedge clk);
        end
        check("rst_mid_no_ack_done", stray, 0);

        // Sequencer is usable again after the mid-sequence reset.
        run_vec(tv[1], 10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/int_seq.md
# int_seq

Interrupt/exception entry sequencer for the NES_SOC CPU core. It arbitrates among `NUM_SRC` external interrupt requesters and the internal exception sources, and decides at instruction boundaries whether to take a trap. It then drives the `intc` control strobes to perform the entry sequence: swap to the supervisor stack, push PSR and PC, load the vector and update privilege/priority. It sits between the CPU control FSM, the memory push path and `intc`.

## Interface
- `NUM_SRC`, default 4: number of external interrupt requesters, range 1–8.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `irq_req`  in  NUM_SRC  level request per source.
- `irq_pri`  in  3*NUM_SRC  priority of source i at bits [3i+2:3i].
- `irq_vec`  in  8*NUM_SRC  vector of source i at bits [8i+7:8i].
- `exc_req`  in  1  exception pending (ACV / illegal opcode / privilege).
- `exc_type`  in  2  00 ACV (x02), 01 illegal (x01), 10 privilege (x00).
- `boundary`  in  1  1-cycle strobe from the CPU FSM: instruction boundary, trap may start.
- `cur_priv`  in  1  current PSR[15]; 1 = user.
- `cur_priority`  in  3  current PSR[10:8].
- `push_ack`  in  1  memory push path has accepted the current push.
- `busy`  out  1  sequence in progress; the CPU FSM stalls fetch.
- `done`  out  1  1-cycle pulse; `table_vector` is valid and the CPU fetches the handler address.
- `irq_ack`  out  NUM_SRC  one-hot 1-cycle pulse to the serviced source.
- `push_req`, `push_sel`  out  1, 1  push request; `push_sel` 0 = PSR, 1 = PC.
- `int_priority`, `int_vec`  out  3, 8  winner's priority and vector, to `intc`.
- `table_mux_sel`, `ld_vector`, `vector_mux`[1:0], `ld_priv`, `set_priv`, `ld_priority`, `psr_mux_sel`, `gate_psr`  out: `intc` controls.
- `ld_saved_usp`, `ld_saved_ssp`, `gate_sp_en`, `sp_mux_sel`[1:0]  out: `intc` stack controls.
- `sr1_sel_r6`, `ld_r6`  out  1, 1  force the SR1 read port to R6; write R6 from the bus.

## Operation
- **Arbiter (combinational):**
  - The winner is the requesting source with the highest `irq_pri`; ties go to the lowest index.
  - The interrupt is eligible only if winner priority > `cur_priority` (strict). Priority 0 is never taken.
- **Accept (IDLE, `boundary`=1):**
  - `exc_req`=1 takes precedence over any interrupt.
  - On accept, latch: kind (exc/irq), `exc_type`, winner index, priority and vector, and `cur_priv`.
  - Later changes of `irq_req`, `irq_pri` or `irq_vec` have no effect on the sequence in progress.
- **States:** IDLE → (SWAP if latched priv=1) → DEC1 → PUSH_PSR → DEC2 → PUSH_PC → LDVEC → DONE → IDLE.
- **SWAP:**
  - `sr1_sel_r6`=1, `ld_saved_usp`=1 (old R6 → saved_usp).
  - `gate_sp_en`=1, `sp_mux_sel`=11 (SAVED_SSP), `ld_r6`=1.
- **DEC1/DEC2:** `sr1_sel_r6`=1, `gate_sp_en`=1, `sp_mux_sel`=10 (minus one), `ld_r6`=1.
- **PUSH_PSR:**
  - `push_req`=1, `push_sel`=0, `gate_psr`=1.
  - Hold until `push_ack`; PSR is pushed with the old priv and priority.
- **PUSH_PC:** `push_req`=1, `push_sel`=1; hold until `push_ack`.
- **LDVEC:**
  - `ld_vector`=1, `table_mux_sel`=1, `ld_priv`=1, `set_priv`=0, `psr_mux_sel`=0.
  - Interrupt: `vector_mux`=11, `ld_priority`=1, `irq_ack`[winner]=1.
  - Exception: `vector_mux`=`exc_type`, `ld_priority`=0, no `irq_ack`.
- **DONE:** `done`=1.
- **Outputs:**
  - All strobes are Moore outputs of the state register.
  - `int_priority` and `int_vec` are driven from the latched values.
  - `busy` = state ≠ IDLE.

## Timing
- **Reset:** state IDLE; every output 0, including `sp_mux_sel`=00, `vector_mux`=00, `irq_ack`=0 and `busy`=0.
- **Reset mid-sequence:** returns to IDLE on the next edge and issues no `irq_ack` or `done`.
- **Latency** from the accepting `boundary` edge to `done` with zero-wait pushes (ack in the same cycle as req):
  - User trap: 7 cycles.
  - Supervisor trap: 6 cycles.
  - Each cycle `push_ack` is withheld adds one cycle.
- **Strobe widths:** `push_req` is held stable until acked, and `push_ack` is ignored outside the push states. `done` and `irq_ack` are exactly 1 cycle wide.
- **Boundary conditions:**
  - `boundary` outside IDLE: ignored.
  - `boundary` with nothing eligible: stay IDLE.
  - `exc_req` and an eligible irq on the same boundary: the exception is served and the irq is re-evaluated at a later boundary.

## Structure
- **Shared package `nes_intc_pkg`:**
  - `sp_mux_sel` codes SP_SAVED_USP=00, SP_PLUS_ONE=01, SP_MINUS_ONE=10, SP_SAVED_SSP=11.
  - `vector_mux`/exception codes.
  - State encoding.
- **Sub-module `int_arb`:** parameterized priority arbiter producing winner index, priority, vector and `eligible`.

## Test plan
- **Supervisor irq:** `cur_priv`=0, `cur_priority`=2, source 1 pri=5 vec=x80, `boundary`, push_ack tied 1 → `done` 6 cycles later; LDVEC has `vector_mux`=11, `int_vec`=x80, `ld_priority`=1, `irq_ack`=0010; SWAP is skipped.
- **User irq:** `cur_priv`=1 → SWAP asserts `ld_saved_usp`, `sp_mux_sel`=11 and `ld_r6`; `done` after 7 cycles.
- **Arbitration and eligibility:** sources 0 and 2 both pri=4 with `cur_priority`=3 → source 0 acked. With `cur_priority`=4 → no accept and `busy` stays 0.
- **Exception precedence:** `exc_req`=1 `exc_type`=10 together with an eligible irq → `vector_mux`=10, `ld_priority`=0, no `irq_ack`.
- **Push backpressure and reset:** `push_ack` withheld 3 cycles in PUSH_PSR → `push_req`, `gate_psr` and `push_sel`=0 held, latency +3. Assert `rst` in PUSH_PC → IDLE next cycle with all outputs 0.
